// File: rtl/serial_paralelo_rx_pkg.sv
// Symbols and state encodings shared by the serial transmit and receive paths,
// so both sides agree on COM/IDL by construction.
package serial_paralelo_rx_pkg;

    localparam logic [7:0] COM             = 8'hBC;
    localparam logic [7:0] IDL             = 8'h7C;
    localparam int         COM_NUM_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sp_shifter.sv
// Serial-in shift register plus 3-bit byte-phase counter for the receive path.
// o_nxt is the window including the bit being sampled on this edge.
module sp_shifter (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       i_data,
    input  logic       i_clr_cnt,
    input  logic       i_cnt_en,
    output logic [7:0] o_nxt,
    output logic       o_at_last_bit
);

    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;

    assign o_nxt         = {r_sr[6:0], i_data};
    assign o_at_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else begin
            r_sr <= o_nxt;
            // Clear wins so a COM found in SEARCH always restarts the byte phase.
            if (i_clr_cnt)
                r_bit_cnt <= 3'd0;
            else if (i_cnt_en)
                r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: COM-based byte alignment, link bring-up after
// COM_NUM aligned COMs, then byte recovery with valid and idle indications.
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter int COM_NUM = COM_NUM_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active,
    output logic       IDLE_OUT
);

    localparam logic [2:0] COM_NUM_W = 3'(COM_NUM);

    rx_state_t  r_state, w_state_nxt;
    logic [2:0] r_com_cnt, w_com_cnt_nxt, w_com_cnt_inc;
    logic [7:0] r_data, w_data_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_strobe, w_strobe_nxt;
    logic       r_active, w_active_nxt;
    logic       r_idle, w_idle_nxt;

    logic [7:0] w_nxt;
    logic       w_at_last_bit;
    logic       w_boundary;
    logic       w_clr_cnt;
    logic       w_cnt_en;

    sp_shifter u_shifter (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .i_data        (data_in),
        .i_clr_cnt     (w_clr_cnt),
        .i_cnt_en      (w_cnt_en),
        .o_nxt         (w_nxt),
        .o_at_last_bit (w_at_last_bit)
    );

    assign w_boundary    = w_at_last_bit && (r_state != SEARCH);
    assign w_com_cnt_inc = r_com_cnt + 3'd1;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_com_cnt <= 3'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
            r_idle    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_strobe  <= w_strobe_nxt;
            r_active  <= w_active_nxt;
            r_idle    <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_com_cnt_nxt = r_com_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_active_nxt  = r_active;
        w_idle_nxt    = r_idle;
        w_strobe_nxt  = 1'b0;
        w_clr_cnt     = 1'b0;
        w_cnt_en      = 1'b0;

        case (r_state)
            SEARCH: begin
                if (w_nxt == COM) begin
                    w_clr_cnt     = 1'b1;
                    w_com_cnt_nxt = 3'd1;
                    if (COM_NUM_W == 3'd1) begin
                        w_state_nxt  = ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ALIGN;
                    end
                end
            end

            ALIGN: begin
                w_cnt_en = 1'b1;
                if (w_boundary) begin
                    if (w_nxt == COM) begin
                        w_com_cnt_nxt = w_com_cnt_inc;
                        if (w_com_cnt_inc == COM_NUM_W) begin
                            w_state_nxt  = ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_com_cnt_nxt = 3'd0;
                        w_state_nxt   = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                w_cnt_en = 1'b1;
                if (w_boundary) begin
                    w_strobe_nxt = 1'b1;
                    if (w_nxt == COM) begin
                        w_valid_nxt = 1'b0;
                    end else if (w_nxt == IDL) begin
                        w_valid_nxt = 1'b0;
                        w_idle_nxt  = 1'b1;
                    end else begin
                        w_data_nxt  = w_nxt;
                        w_valid_nxt = 1'b1;
                        w_idle_nxt  = 1'b0;
                    end
                end
            end

            // Unused encoding 3 falls back to a fresh search.
            default: begin
                w_state_nxt   = SEARCH;
                w_com_cnt_nxt = 3'd0;
            end
        endcase
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;
    assign IDLE_OUT    = r_idle;

endmodule
